next_state_sequencer: RTL and testbench

//  Control-unit microsequencer. Holds the 7-bit current-state register that drives the microstore

---
 rtl/next_state_sequencer.sv | 125 ++++++++++++
 tb/tb_next_state_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/next_state_sequencer.sv
// Microsequencer: holds the microstore address register and computes the next
// microstate from the sequencing fields, datapath conditions and a memory-wait watchdog.
module next_state_sequencer #(
  parameter int SW        = 7,
  parameter int MAX_STATE = 44,
  parameter int ERR_STATE = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    n_sel,
  input  logic          inv,
  input  logic [1:0]    cond_sel,
  input  logic [SW-1:0] cr_addr,
  input  logic [SW-1:0] enc_state,
  input  logic          moc,
  input  logic          br_cond,
  input  logic          irq,
  output logic [SW-1:0] current_state,
  output logic          illegal_state,
  output logic          timeout_err,
  output logic [4:0]    wait_cnt
);

  localparam logic [SW-1:0] MAX_S   = SW'(MAX_STATE);
  localparam logic [SW-1:0] ERR_S   = SW'(ERR_STATE);
  localparam logic [4:0]    TO_LAST = 5'(TIMEOUT - 1);
  localparam logic          WD_EN   = (TIMEOUT > 0);

  logic [SW-1:0] state_q, state_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic [4:0]    wait_q, wait_d;

  logic          sel_cond_s;
  logic          cond_s;
  logic [SW-1:0] inc_s;
  logic [SW-1:0] mux_s;
  logic          hold_s;
  logic          wd_fire_s;

  // Condition select and polarity
  always_comb begin
    sel_cond_s = 1'b0;
    case (cond_sel)
      2'b00:   sel_cond_s = moc;
      2'b01:   sel_cond_s = br_cond;
      2'b10:   sel_cond_s = 1'b1;
      2'b11:   sel_cond_s = irq;
      default: sel_cond_s = 1'b0;
    endcase
    cond_s = sel_cond_s ^ inv;
  end

  assign inc_s = state_q + SW'(1);

  // Sequencing-mode mux
  always_comb begin
    mux_s = '0;
    case (n_sel)
      3'b000:  mux_s = enc_state;
      3'b001:  mux_s = '0;
      3'b010:  mux_s = cr_addr;
      3'b011:  mux_s = inc_s;
      3'b100:  mux_s = cond_s ? cr_addr : inc_s;
      3'b101:  mux_s = cond_s ? cr_addr : enc_state;
      3'b110:  mux_s = cond_s ? inc_s : state_q;
      3'b111:  mux_s = cond_s ? cr_addr : '0;
      default: mux_s = '0;
    endcase
  end

  assign hold_s    = (n_sel == 3'b110) && !cond_s;
  assign wd_fire_s = WD_EN && hold_s && (wait_q == TO_LAST);

  // Next state: watchdog beats the legality check, which beats the mode mux
  always_comb begin
    state_d   = mux_s;
    illegal_d = 1'b0;
    if (wd_fire_s) begin
      state_d   = ERR_S;
      illegal_d = 1'b0;
    end else if (mux_s > MAX_S) begin
      state_d   = '0;
      illegal_d = 1'b1;
    end else begin
      state_d   = mux_s;
      illegal_d = 1'b0;
    end
  end

  // Hold counter (saturating) and sticky timeout flag
  always_comb begin
    wait_d    = 5'd0;
    timeout_d = timeout_q | wd_fire_s;
    if (wd_fire_s) begin
      wait_d = 5'd0;
    end else if (hold_s) begin
      wait_d = (wait_q == 5'd31) ? 5'd31 : wait_q + 5'd1;
    end else begin
      wait_d = 5'd0;
    end
  end

  // The only register on the microstore feedback loop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= 5'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

  assign current_state = state_q;
  assign illegal_state = illegal_q;
  assign timeout_err   = timeout_q;
  assign wait_cnt      = wait_q;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Directed bench for next_state_sequencer: default instance plus a wide-range,
// watchdog-disabled instance for the wrap and TIMEOUT=0 cases.
module tb_next_state_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] n_sel = 3'b000;
  logic       inv = 1'b0;
  logic [1:0] cond_sel = 2'b00;
  logic [6:0] cr_addr = 7'd0;
  logic [6:0] enc_state = 7'd0;
  logic       moc = 1'b0;
  logic       br_cond = 1'b0;
  logic       irq = 1'b0;

  logic [6:0] cs, w_cs;
  logic       ill, w_ill, te, w_te;
  logic [4:0] wc, w_wc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  next_state_sequencer u_dut (
    .clk(clk), .reset(reset), .n_sel(n_sel), .inv(inv), .cond_sel(cond_sel),
    .cr_addr(cr_addr), .enc_state(enc_state), .moc(moc), .br_cond(br_cond), .irq(irq),
    .current_state(cs), .illegal_state(ill), .timeout_err(te), .wait_cnt(wc)
  );

  next_state_sequencer #(.SW(7), .MAX_STATE(127), .ERR_STATE(0), .TIMEOUT(0)) u_wrap (
    .clk(clk), .reset(reset), .n_sel(n_sel), .inv(inv), .cond_sel(cond_sel),
    .cr_addr(cr_addr), .enc_state(enc_state), .moc(moc), .br_cond(br_cond), .irq(irq),
    .current_state(w_cs), .illegal_state(w_ill), .timeout_err(w_te), .wait_cnt(w_wc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] s);
    n_sel = 3'b010; cr_addr = s; inv = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; n_sel = 3'b010; cr_addr = 7'd9;
    step(); step();
    n_tests++; if (cs !== 7'd0) begin $display("FAIL reset_state got %0d want 0", cs); n_fail++; end
    n_tests++; if (te !== 1'b0 || ill !== 1'b0 || wc !== 5'd0) begin
      $display("FAIL reset_flags got te=%0b ill=%0b wc=%0d want 0/0/0", te, ill, wc); n_fail++; end
    reset = 1'b0; step();
    n_tests++; if (cs !== 7'd9) begin $display("FAIL reset_release got %0d want 9", cs); n_fail++; end
  endtask

  task automatic test_modes();
    load(7'd1);
    n_sel = 3'b000; enc_state = 7'd16; step();
    n_tests++; if (cs !== 7'd16) begin $display("FAIL enc_state got %0d want 16", cs); n_fail++; end
    n_sel = 3'b001; step();
    n_tests++; if (cs !== 7'd0) begin $display("FAIL fetch got %0d want 0", cs); n_fail++; end
    load(7'd44);
    n_tests++; if (cs !== 7'd44 || ill !== 1'b0) begin
      $display("FAIL max_legal got %0d ill=%0b want 44 ill=0", cs, ill); n_fail++; end
    n_sel = 3'b011; step();
    n_tests++; if (cs !== 7'd0 || ill !== 1'b1) begin
      $display("FAIL illegal_inc got %0d ill=%0b want 0 ill=1", cs, ill); n_fail++; end
    load(7'd5);
    n_tests++; if (cs !== 7'd5 || ill !== 1'b0) begin
      $display("FAIL illegal_pulse_end got %0d ill=%0b want 5 ill=0", cs, ill); n_fail++; end
  endtask

  task automatic test_branch();
    load(7'd7);
    n_sel = 3'b100; cond_sel = 2'b01; inv = 1'b0; cr_addr = 7'd12; br_cond = 1'b1; step();
    n_tests++; if (cs !== 7'd12) begin $display("FAIL br_taken got %0d want 12", cs); n_fail++; end
    load(7'd7);
    n_sel = 3'b100; cr_addr = 7'd12; br_cond = 1'b0; step();
    n_tests++; if (cs !== 7'd8) begin $display("FAIL br_not_taken got %0d want 8", cs); n_fail++; end
    inv = 1'b1; br_cond = 1'b1; step();
    n_tests++; if (cs !== 7'd9) begin $display("FAIL br_inv_true got %0d want 9", cs); n_fail++; end
    br_cond = 1'b0; step();
    n_tests++; if (cs !== 7'd12) begin $display("FAIL br_inv_false got %0d want 12", cs); n_fail++; end
    n_sel = 3'b101; cond_sel = 2'b11; inv = 1'b0; irq = 1'b1; cr_addr = 7'd20; enc_state = 7'd3; step();
    n_tests++; if (cs !== 7'd20) begin $display("FAIL irq_taken got %0d want 20", cs); n_fail++; end
    irq = 1'b0; step();
    n_tests++; if (cs !== 7'd3) begin $display("FAIL irq_enc got %0d want 3", cs); n_fail++; end
  endtask

  task automatic test_hold();
    load(7'd3);
    n_sel = 3'b110; cond_sel = 2'b00; inv = 1'b0; moc = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++; if (cs !== 7'd3 || wc !== 5'(i)) begin
        $display("FAIL hold_%0d got state=%0d wc=%0d want 3/%0d", i, cs, wc, i); n_fail++; end
    end
    moc = 1'b1; step();
    n_tests++; if (cs !== 7'd4 || wc !== 5'd0) begin
      $display("FAIL hold_release got state=%0d wc=%0d want 4/0", cs, wc); n_fail++; end
  endtask

  task automatic test_timeout();
    do_reset();
    load(7'd5);
    n_sel = 3'b110; cond_sel = 2'b00; inv = 1'b0; moc = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      n_tests++; if (cs !== 7'd5 || wc !== 5'(i) || te !== 1'b0) begin
        $display("FAIL wd_count_%0d got state=%0d wc=%0d te=%0b want 5/%0d/0", i, cs, wc, te, i); n_fail++; end
    end
    step();
    n_tests++; if (cs !== 7'd0 || te !== 1'b1 || wc !== 5'd0 || ill !== 1'b0) begin
      $display("FAIL wd_fire got state=%0d te=%0b wc=%0d ill=%0b want 0/1/0/0", cs, te, wc, ill); n_fail++; end
    moc = 1'b1; n_sel = 3'b011; step();
    n_tests++; if (cs !== 7'd1 || te !== 1'b1) begin
      $display("FAIL wd_sticky got state=%0d te=%0b want 1/1", cs, te); n_fail++; end
    load(7'd6);
    n_sel = 3'b110; moc = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1; step(); reset = 1'b0;
    n_tests++; if (cs !== 7'd0 || te !== 1'b0 || wc !== 5'd0) begin
      $display("FAIL reset_mid_wait got state=%0d te=%0b wc=%0d want 0/0/0", cs, te, wc); n_fail++; end
  endtask

  task automatic test_wrap();
    do_reset();
    load(7'd127);
    n_tests++; if (w_cs !== 7'd127) begin $display("FAIL wrap_load got %0d want 127", w_cs); n_fail++; end
    n_tests++; if (cs !== 7'd0 || ill !== 1'b1) begin
      $display("FAIL illegal_cr got %0d ill=%0b want 0 ill=1", cs, ill); n_fail++; end
    n_sel = 3'b011; step();
    n_tests++; if (w_cs !== 7'd0 || w_ill !== 1'b0) begin
      $display("FAIL wrap_inc got %0d ill=%0b want 0 ill=0", w_cs, w_ill); n_fail++; end
    n_sel = 3'b111; cond_sel = 2'b10; inv = 1'b0; cr_addr = 7'd30; step();
    n_tests++; if (cs !== 7'd30) begin $display("FAIL mode111_const got %0d want 30", cs); n_fail++; end
    inv = 1'b1; step();
    n_tests++; if (cs !== 7'd0) begin $display("FAIL mode111_inv got %0d want 0", cs); n_fail++; end
    load(7'd30);
    n_sel = 3'b110; cond_sel = 2'b10; inv = 1'b1;
    for (int i = 0; i < 35; i++) step();
    n_tests++; if (w_cs !== 7'd30 || w_wc !== 5'd31 || w_te !== 1'b0) begin
      $display("FAIL no_wd_saturate got state=%0d wc=%0d te=%0b want 30/31/0", w_cs, w_wc, w_te); n_fail++; end
    inv = 1'b0; n_sel = 3'b001; step();
    n_tests++; if (w_wc !== 5'd0) begin $display("FAIL wc_clear got %0d want 0", w_wc); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_branch();
    test_hold();
    test_timeout();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
